// File: rtl/shift_idx_recover.sv
// Sequential one-hot index reader: shifts an accepted vector right until empty and
// returns the lowest set bit index. Optional multi-hot flag under SHIFT_IDX_RECOVER_MULTI_EN.
module shift_idx_recover #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
  output logic             out_multi,
`endif
  output logic             out_zero
);

  localparam int unsigned LAST_CNT = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic             zero;
  logic             accept_c;
  logic             scan_exit_c;
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
  logic             multi;
`endif

  // Multi-hot mode must see every set bit; otherwise the first set bit ends the scan.
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
  assign scan_exit_c = ((sreg >> 1) == '0) || (cnt == IDX_W'(LAST_CNT));
`else
  assign scan_exit_c = ((sreg >> 1) == '0) || (cnt == IDX_W'(LAST_CNT)) || sreg[0];
`endif

  assign accept_c  = in_valid && in_ready;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_idx   = idx;
  assign out_zero  = zero;
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
  assign out_multi = multi;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = SCAN;
      SCAN:    if (scan_exit_c) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, shift/count during SCAN, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg  <= '0;
      cnt   <= '0;
      idx   <= '0;
      found <= 1'b0;
      zero  <= 1'b0;
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
      multi <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            sreg  <= in_vec;
            cnt   <= '0;
            idx   <= '0;
            found <= 1'b0;
            zero  <= 1'b0;
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
            multi <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (sreg[0] && !found) begin
            idx   <= cnt;
            found <= 1'b1;
          end
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
          if (sreg[0] && found) multi <= 1'b1;
`endif
          sreg <= sreg >> 1;
          if (!scan_exit_c) cnt <= cnt + IDX_W'(1);
          zero <= !(found || sreg[0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_idx_recover.sv
// Directed self-checking bench for shift_idx_recover; expectations adapt to
// SHIFT_IDX_RECOVER_MULTI_EN.
module tb_shift_idx_recover;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_zero;
  logic             multi_obs;

  int vec_cnt = 0;
  int err_cnt = 0;

  shift_idx_recover #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vec(in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
    .out_multi(multi_obs),
`endif
    .out_zero(out_zero)
  );

`ifndef SHIFT_IDX_RECOVER_MULTI_EN
  assign multi_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  // Stimulus driver: offer vec, accept, then count edges until out_valid (no checks).
  task automatic run_vec(input logic [WIDTH-1:0] vec, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_vec   = vec;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = '0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_idx !== '0 ||
        out_zero !== 1'b0 || multi_obs !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: valid=%b ready=%b idx=%0d zero=%b multi=%b, want all 0",
               out_valid, in_ready, out_idx, out_zero, multi_obs);
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single(input string name, input logic [WIDTH-1:0] vec,
                             input int exp_lat, input logic [IDX_W-1:0] exp_idx,
                             input logic exp_zero, input logic exp_multi);
    int lat;
    out_ready = 1'b1;
    run_vec(vec, lat);
    vec_cnt++;
    if (lat !== exp_lat || out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, lat, out_valid, exp_lat);
    end
    vec_cnt++;
    if (out_idx !== exp_idx || out_zero !== exp_zero || multi_obs !== exp_multi) begin
      err_cnt++;
      $display("FAIL %s result: idx=%0d zero=%b multi=%b want idx=%0d zero=%b multi=%b",
               name, out_idx, out_zero, multi_obs, exp_idx, exp_zero, exp_multi);
    end
    @(posedge clk); #1;
  endtask

  // One-hot encoder model: decode(encode(i)) must give back i with latency i+1.
  task automatic test_onehot_loop();
    logic [WIDTH-1:0] enc;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      enc = '0;
      enc[i] = 1'b1;
      run_vec(enc, lat);
      vec_cnt++;
      if (out_idx !== IDX_W'(i) || lat !== i + 1 || out_zero !== 1'b0 || multi_obs !== 1'b0) begin
        err_cnt++;
        $display("FAIL onehot_%0d: idx=%0d lat=%0d zero=%b multi=%b want idx=%0d lat=%0d zero=0 multi=0",
                 i, out_idx, lat, out_zero, multi_obs, i, i + 1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    run_vec(8'h04, lat);
    vec_cnt++;
    if (lat !== 3 || out_idx !== 4'd2) begin
      err_cnt++;
      $display("FAIL bp_first: lat=%0d idx=%0d want lat=3 idx=2", lat, out_idx);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vec_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== 4'd2 || out_zero !== 1'b0) begin
        err_cnt++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b idx=%0d zero=%b want 1 0 2 0",
                 c, out_valid, in_ready, out_idx, out_zero);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_release: ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
    run_vec(8'h10, lat);
    vec_cnt++;
    if (out_idx !== 4'd4 || lat !== 5) begin
      err_cnt++;
      $display("FAIL bp_second: idx=%0d lat=%0d want idx=4 lat=5", out_idx, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_scan_reset();
    int lat;
    bit seen;
    out_ready = 1'b1;
    seen = 1'b0;
    in_valid = 1'b1;
    in_vec   = 8'h80;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = '0;
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (out_valid) seen = 1'b1;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== '0 ||
        out_zero !== 1'b0 || multi_obs !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_idle: ready=%b valid=%b idx=%0d zero=%b multi=%b want 1 0 0 0 0",
               in_ready, out_valid, out_idx, out_zero, multi_obs);
    end
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vec_cnt++;
    if (seen) begin
      err_cnt++;
      $display("FAIL rst_discard: out_valid got 1 want 0 after mid-scan reset");
    end
    run_vec(8'h02, lat);
    vec_cnt++;
    if (out_idx !== 4'd1 || lat !== 2) begin
      err_cnt++;
      $display("FAIL rst_next: idx=%0d lat=%0d want idx=1 lat=2", out_idx, lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single("vec01", 8'h01, 1, 4'd0, 1'b0, 1'b0);
    test_single("vec80", 8'h80, 8, 4'd7, 1'b0, 1'b0);
    test_single("vec00", 8'h00, 1, 4'd0, 1'b1, 1'b0);
`ifdef SHIFT_IDX_RECOVER_MULTI_EN
    test_single("vecA0", 8'hA0, 8, 4'd5, 1'b0, 1'b1);
    test_single("vecFF", 8'hFF, 8, 4'd0, 1'b0, 1'b1);
    test_single("vec06", 8'h06, 3, 4'd1, 1'b0, 1'b1);
`else
    test_single("vecA0", 8'hA0, 6, 4'd5, 1'b0, 1'b0);
    test_single("vecFF", 8'hFF, 1, 4'd0, 1'b0, 1'b0);
    test_single("vec06", 8'h06, 2, 4'd1, 1'b0, 1'b0);
`endif
    test_onehot_loop();
    test_backpressure();
    test_mid_scan_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

endmodule
